popcount_match: RTL

POPCOUNT_MATCH -- requirements
Module: popcount_match

---
 rtl/popcount_match.sv | 112 +++++++++++
 1 files changed

// File: rtl/popcount_match.sv
// Two-stage popcount-and-compare pipeline with valid/ready handshakes on both
// sides and a saturating count of delivered matches.
module popcount_match #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH + 1),
   parameter int TOT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [CNT_W-1:0] target,
   input  logic [1:0]       mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] out_count,
   output logic             out_match,
   input  logic             clr_total,
   output logic [TOT_W-1:0] match_total,
   output logic             total_sat
);

   localparam logic [TOT_W-1:0] TOT_MAX = {TOT_W{1'b1}};

   logic             r_s1_vld;
   logic [CNT_W-1:0] r_s1_cnt;
   logic [CNT_W-1:0] r_s1_tgt;
   logic [1:0]       r_s1_mode;
   logic             r_s2_vld;
   logic [CNT_W-1:0] r_s2_cnt;
   logic             r_s2_match;
   logic [TOT_W-1:0] r_total;
   logic             r_sat;

   logic [CNT_W-1:0] w_pop;
   logic             w_match;
   logic             w_s2_free;
   logic             w_s2_load;
   logic             w_in_xfer;
   logic             w_out_xfer;

   always_comb begin
      w_pop = '0;
      for (int i = 0; i < WIDTH; i++) w_pop = w_pop + CNT_W'(in_data[i]);
   end

   // Unsigned compare on CNT_W bits; a target above WIDTH falls out naturally.
   always_comb begin
      w_match = 1'b0;
      case (r_s1_mode)
         2'b00:   w_match = (r_s1_cnt == r_s1_tgt);
         2'b01:   w_match = (r_s1_cnt >= r_s1_tgt);
         2'b10:   w_match = (r_s1_cnt <= r_s1_tgt);
         default: w_match = (r_s1_cnt != r_s1_tgt);
      endcase
   end

   assign w_out_xfer = r_s2_vld && out_ready;
   assign w_s2_free  = !r_s2_vld || out_ready;
   assign w_s2_load  = r_s1_vld && w_s2_free;
   assign in_ready   = !r_s1_vld || w_s2_free;
   assign w_in_xfer  = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_vld  <= 1'b0;
         r_s1_cnt  <= '0;
         r_s1_tgt  <= '0;
         r_s1_mode <= 2'b00;
      end else if (w_in_xfer) begin
         r_s1_vld  <= 1'b1;
         r_s1_cnt  <= w_pop;
         r_s1_tgt  <= target;
         r_s1_mode <= mode;
      end else if (w_s2_load) begin
         r_s1_vld  <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s2_vld   <= 1'b0;
         r_s2_cnt   <= '0;
         r_s2_match <= 1'b0;
      end else if (w_s2_load) begin
         r_s2_vld   <= 1'b1;
         r_s2_cnt   <= r_s1_cnt;
         r_s2_match <= w_match;
      end else if (w_out_xfer) begin
         r_s2_vld   <= 1'b0;
      end
   end

   // Clear wins over a same-cycle increment; saturation flag is sticky.
   always_ff @(posedge clk) begin
      if (rst || clr_total) begin
         r_total <= '0;
         r_sat   <= 1'b0;
      end else if (w_out_xfer && r_s2_match) begin
         if (r_total == TOT_MAX) r_sat <= 1'b1;
         else                    r_total <= r_total + 1'b1;
      end
   end

   assign out_valid   = r_s2_vld;
   assign out_count   = r_s2_cnt;
   assign out_match   = r_s2_match;
   assign match_total = r_total;
   assign total_sat   = r_sat;

endmodule
